// File: rtl/instr_decode_pipe_pkg.sv
// Shared types for the instruction decode pipe: operation classes, the decoded
// control bundle and instruction field positions.
package decode_pkg;

   // Widest supported immediate; the top trims it to its DATA_W.
   localparam int INM_W = 64;

   localparam int COND_HI  = 31;
   localparam int COND_LO  = 28;
   localparam int CLASS_HI = 27;
   localparam int CLASS_LO = 26;
   localparam int I_BIT    = 25;
   localparam int P_BIT    = 24;
   localparam int U_BIT    = 23;
   localparam int B_BIT    = 22;
   localparam int W_BIT    = 21;
   localparam int L_BIT    = 20;
   localparam int S_BIT    = 20;
   localparam int LINK_BIT = 24;

   typedef enum logic [1:0] {
      OP_DP  = 2'd0,
      OP_MEM = 2'd1,
      OP_BR  = 2'd2,
      OP_ILL = 2'd3
   } op_class_t;

   typedef struct packed {
      logic [3:0]       cond;
      op_class_t        op_class;
      logic [3:0]       funct;
      logic             set_flags;
      logic             use_imm;
      logic [3:0]       rd;
      logic [3:0]       rs;
      logic [3:0]       rm;
      logic [INM_W-1:0] inm;
      logic             use_mem;
      logic             w_mem;
      logic             up;
      logic             byte_acc;
      logic             pre_idx;
      logic             wback;
      logic             link;
      logic             illegal;
   } decoded_t;

endpackage

// File: rtl/instr_decode_pipe_fields.sv
// Combinational field decoder: one 32-bit instruction word in, one control
// bundle out, including the rotated-immediate and branch-offset expansion.
module decode_fields
   import decode_pkg::*;
(
   input  logic [31:0] instruction,
   output decoded_t    dec
);

   function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] sh);
      logic [63:0] dbl;
      dbl = {v, v} >> sh;
      return dbl[31:0];
   endfunction

   // Word offset: sign-extend imm24 to the full immediate width, then scale by 4.
   function automatic logic signed [INM_W-1:0] br_offset(input logic [23:0] imm24);
      logic signed [INM_W-1:0] ext;
      ext = {{(INM_W-24){imm24[23]}}, imm24};
      return ext <<< 2;
   endfunction

   always_comb begin
      dec      = '0;
      dec.cond = instruction[COND_HI:COND_LO];
      case (instruction[CLASS_HI:CLASS_LO])
         2'b00: begin
            dec.op_class  = OP_DP;
            dec.funct     = instruction[24:21];
            dec.set_flags = instruction[S_BIT];
            dec.rd        = instruction[15:12];
            dec.rs        = instruction[19:16];
            if (instruction[I_BIT]) begin
               dec.use_imm = 1'b1;
               dec.inm     = INM_W'(ror32({24'd0, instruction[7:0]}, {instruction[11:8], 1'b0}));
            end else begin
               dec.rm = instruction[3:0];
            end
         end
         2'b01: begin
            dec.op_class = OP_MEM;
            dec.rd       = instruction[15:12];
            dec.rs       = instruction[19:16];
            dec.use_mem  = 1'b1;
            dec.w_mem    = !instruction[L_BIT];
            dec.up       = instruction[U_BIT];
            dec.byte_acc = instruction[B_BIT];
            dec.pre_idx  = instruction[P_BIT];
            dec.wback    = instruction[W_BIT];
            // The I bit is inverted for memory: clear means immediate offset.
            if (!instruction[I_BIT]) begin
               dec.use_imm = 1'b1;
               dec.inm     = INM_W'(instruction[11:0]);
            end else begin
               dec.rm = instruction[3:0];
            end
         end
         2'b10: begin
            dec.op_class = OP_BR;
            dec.link     = instruction[LINK_BIT];
            dec.inm      = br_offset(instruction[23:0]);
         end
         default: begin
            dec.op_class = OP_ILL;
            dec.illegal  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/instr_decode_pipe.sv
// Decode stage between fetch and register read: handshaked on both sides,
// optional skid slot for full throughput under backpressure, flush and counter.
module instr_decode_pipe
   import decode_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int SKID_EN = 1,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       instruction,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        cond,
   output logic [1:0]        op_class,
   output logic [3:0]        funct,
   output logic              set_flags,
   output logic              use_imm,
   output logic [3:0]        rd,
   output logic [3:0]        rs,
   output logic [3:0]        rm,
   output logic [DATA_W-1:0] inm,
   output logic              useMemory,
   output logic              wMemory,
   output logic              up,
   output logic              byte_acc,
   output logic              pre_idx,
   output logic              wback,
   output logic              link,
   output logic              illegal,
   output logic [CNT_W-1:0]  dec_count
);

   decoded_t dec_p0;
   decoded_t main_p1;
   decoded_t skid_p1;
   logic     vld_p1;
   logic     skid_vld_p1;
   logic     accept;
   logic     drain;

   decode_fields u_fields (
      .instruction (instruction),
      .dec         (dec_p0)
   );

   // While reset is held the decoder advertises ready but ignores the input.
   assign in_ready = !reset ? 1'b1 :
                     (SKID_EN != 0) ? !skid_vld_p1 : (!vld_p1 || out_ready);
   assign accept   = in_valid && in_ready;
   assign drain    = vld_p1 && out_ready;

   // ---- stage p0 -> p1: slot update ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_p1      <= 1'b0;
         skid_vld_p1 <= 1'b0;
         main_p1     <= '0;
         skid_p1     <= '0;
         dec_count   <= '0;
      end else begin
         if (drain)
            dec_count <= dec_count + CNT_W'(1);
         if (flush) begin
            vld_p1      <= 1'b0;
            skid_vld_p1 <= 1'b0;
         end else if (SKID_EN != 0) begin
            if (drain) begin
               if (skid_vld_p1) begin
                  main_p1     <= skid_p1;
                  skid_vld_p1 <= 1'b0;
               end else if (accept) begin
                  main_p1 <= dec_p0;
               end else begin
                  vld_p1 <= 1'b0;
               end
            end else if (accept) begin
               if (!vld_p1) begin
                  main_p1 <= dec_p0;
                  vld_p1  <= 1'b1;
               end else begin
                  skid_p1     <= dec_p0;
                  skid_vld_p1 <= 1'b1;
               end
            end
         end else begin
            if (accept) begin
               main_p1 <= dec_p0;
               vld_p1  <= 1'b1;
            end else if (drain) begin
               vld_p1 <= 1'b0;
            end
         end
      end
   end

   // ---- stage p1: output bundle ----
   assign out_valid = vld_p1;
   assign cond      = main_p1.cond;
   assign op_class  = main_p1.op_class;
   assign funct     = main_p1.funct;
   assign set_flags = main_p1.set_flags;
   assign use_imm   = main_p1.use_imm;
   assign rd        = main_p1.rd;
   assign rs        = main_p1.rs;
   assign rm        = main_p1.rm;
   assign inm       = main_p1.inm[DATA_W-1:0];
   assign useMemory = main_p1.use_mem;
   assign wMemory   = main_p1.w_mem;
   assign up        = main_p1.up;
   assign byte_acc  = main_p1.byte_acc;
   assign pre_idx   = main_p1.pre_idx;
   assign wback     = main_p1.wback;
   assign link      = main_p1.link;
   assign illegal   = main_p1.illegal;

   if (DATA_W < INM_W) begin : g_trim
      logic unused_inm_hi;
      assign unused_inm_hi = ^main_p1.inm[INM_W-1:DATA_W];
   end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe: decode vectors, skid backpressure,
// flush and mid-stream reset.
module tb_instr_decode_pipe;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       instruction;
   logic              out_valid;
   logic              out_ready;
   logic [3:0]        cond;
   logic [1:0]        op_class;
   logic [3:0]        funct;
   logic              set_flags;
   logic              use_imm;
   logic [3:0]        rd;
   logic [3:0]        rs;
   logic [3:0]        rm;
   logic [DATA_W-1:0] inm;
   logic              useMemory;
   logic              wMemory;
   logic              up;
   logic              byte_acc;
   logic              pre_idx;
   logic              wback;
   logic              link;
   logic              illegal;
   logic [CNT_W-1:0]  dec_count;

   int n_checks = 0;
   int n_fail   = 0;

   instr_decode_pipe #(.DATA_W(DATA_W), .SKID_EN(1), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .instruction (instruction),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .cond        (cond),
      .op_class    (op_class),
      .funct       (funct),
      .set_flags   (set_flags),
      .use_imm     (use_imm),
      .rd          (rd),
      .rs          (rs),
      .rm          (rm),
      .inm         (inm),
      .useMemory   (useMemory),
      .wMemory     (wMemory),
      .up          (up),
      .byte_acc    (byte_acc),
      .pre_idx     (pre_idx),
      .wback       (wback),
      .link        (link),
      .illegal     (illegal),
      .dec_count   (dec_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction with the consumer ready and check the bundle it produces.
   task automatic run_vec(input string name, input logic [31:0] ins,
                          input logic [1:0] cls, input logic [3:0] fn,
                          input logic [3:0] e_rd, input logic [3:0] e_rs, input logic [3:0] e_rm,
                          input logic [31:0] imm, input logic ui, input logic [5:0] memf,
                          input logic lk, input logic sf);
      instruction = ins;
      in_valid    = 1'b1;
      step();
      check_eq({name, ".valid"}, out_valid, 1'b1);
      check_eq({name, ".cond"}, cond, ins[31:28]);
      check_eq({name, ".class"}, op_class, cls);
      check_eq({name, ".funct"}, funct, fn);
      check_eq({name, ".regs"}, {rd, rs, rm}, {e_rd, e_rs, e_rm});
      check_eq({name, ".inm"}, inm, imm);
      check_eq({name, ".use_imm"}, use_imm, ui);
      check_eq({name, ".memflags"}, {useMemory, wMemory, up, byte_acc, pre_idx, wback}, memf);
      check_eq({name, ".link"}, link, lk);
      check_eq({name, ".set_flags"}, set_flags, sf);
      check_eq({name, ".illegal"}, illegal, (cls == 2'd3));
   endtask

   initial begin
      reset       = 1'b0;
      flush       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      instruction = 32'h0;
      step();
      step();
      check_eq("rst.out_valid", out_valid, 1'b0);
      check_eq("rst.dec_count", dec_count, 16'd0);
      check_eq("rst.in_ready", in_ready, 1'b1);
      check_eq("rst.inm", inm, 32'd0);
      check_eq("rst.cond", cond, 4'd0);
      reset = 1'b1;
      step();

      // ---- decode vectors, consumer always ready ----
      out_ready = 1'b1;
      //        name      instruction   cls   fn     rd     rs     rm     inm            ui    mem         lk    sf
      run_vec("dp_addi",  32'hE2821004, 2'd0, 4'h4, 4'd1, 4'd2, 4'd0, 32'h00000004, 1'b1, 6'b000000, 1'b0, 1'b0);
      run_vec("dp_rot",   32'hE3A004FF, 2'd0, 4'hD, 4'd0, 4'd0, 4'd0, 32'hFF000000, 1'b1, 6'b000000, 1'b0, 1'b0);
      run_vec("dp_reg",   32'hE0913002, 2'd0, 4'h4, 4'd3, 4'd1, 4'd2, 32'h00000000, 1'b0, 6'b000000, 1'b0, 1'b1);
      run_vec("dp_cond0", 32'h02821004, 2'd0, 4'h4, 4'd1, 4'd2, 4'd0, 32'h00000004, 1'b1, 6'b000000, 1'b0, 1'b0);
      run_vec("str_imm",  32'hE5843008, 2'd1, 4'h0, 4'd3, 4'd4, 4'd0, 32'h00000008, 1'b1, 6'b111010, 1'b0, 1'b0);
      run_vec("ldr_neg",  32'hE5143008, 2'd1, 4'h0, 4'd3, 4'd4, 4'd0, 32'h00000008, 1'b1, 6'b100010, 1'b0, 1'b0);
      run_vec("str_wb",   32'hE5A43008, 2'd1, 4'h0, 4'd3, 4'd4, 4'd0, 32'h00000008, 1'b1, 6'b111011, 1'b0, 1'b0);
      run_vec("ldrb_reg", 32'hE7D43002, 2'd1, 4'h0, 4'd3, 4'd4, 4'd2, 32'h00000000, 1'b0, 6'b101110, 1'b0, 1'b0);
      run_vec("b_back",   32'hEAFFFFFE, 2'd2, 4'h0, 4'd0, 4'd0, 4'd0, 32'hFFFFFFF8, 1'b0, 6'b000000, 1'b0, 1'b0);
      run_vec("bl_fwd",   32'hEB000010, 2'd2, 4'h0, 4'd0, 4'd0, 4'd0, 32'h00000040, 1'b0, 6'b000000, 1'b1, 1'b0);
      run_vec("illegal",  32'hEC000000, 2'd3, 4'h0, 4'd0, 4'd0, 4'd0, 32'h00000000, 1'b0, 6'b000000, 1'b0, 1'b0);
      in_valid = 1'b0;
      step();
      check_eq("drain.out_valid", out_valid, 1'b0);
      check_eq("drain.dec_count", dec_count, 16'd11);

      // ---- backpressure through the skid slot ----
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = 32'hE2801001;
      check_eq("bp.ready_empty", in_ready, 1'b1);
      step();
      check_eq("bp.first_rd", rd, 4'd1);
      instruction = 32'hE2802002;
      check_eq("bp.ready_main", in_ready, 1'b1);
      step();
      check_eq("bp.ready_full", in_ready, 1'b0);
      check_eq("bp.hold_rd", rd, 4'd1);
      instruction = 32'hE2803003;
      step();
      check_eq("bp.stall_ready", in_ready, 1'b0);
      check_eq("bp.stall_valid", out_valid, 1'b1);
      check_eq("bp.stall_rd", rd, 4'd1);
      check_eq("bp.stall_inm", inm, 32'd1);
      check_eq("bp.stall_count", dec_count, 16'd11);
      out_ready = 1'b1;
      step();
      check_eq("bp.second_rd", rd, 4'd2);
      check_eq("bp.second_inm", inm, 32'd2);
      check_eq("bp.ready_again", in_ready, 1'b1);
      step();
      check_eq("bp.third_rd", rd, 4'd3);
      check_eq("bp.third_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      step();
      check_eq("bp.empty", out_valid, 1'b0);
      check_eq("bp.dec_count", dec_count, 16'd14);

      // ---- flush with main full and a same-cycle accept into skid ----
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = 32'hE2804004;
      step();
      instruction = 32'hE2805005;
      flush       = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_eq("fl1.out_valid", out_valid, 1'b0);
      check_eq("fl1.in_ready", in_ready, 1'b1);
      step();
      check_eq("fl1.dropped", out_valid, 1'b0);

      // ---- flush with both slots full while a new word is offered ----
      in_valid    = 1'b1;
      instruction = 32'hE2806006;
      step();
      instruction = 32'hE2807007;
      step();
      check_eq("fl2.full", in_ready, 1'b0);
      instruction = 32'hE2808008;
      flush       = 1'b1;
      step();
      flush = 1'b0;
      check_eq("fl2.out_valid", out_valid, 1'b0);
      check_eq("fl2.in_ready", in_ready, 1'b1);
      check_eq("fl2.dec_count", dec_count, 16'd14);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check_eq("fl2.after", out_valid, 1'b0);
      check_eq("fl2.count_after", dec_count, 16'd14);

      // ---- reset mid-stream, with flush also raised ----
      out_ready   = 1'b0;
      in_valid    = 1'b1;
      instruction = 32'hE2809009;
      step();
      instruction = 32'hE280A00A;
      step();
      reset = 1'b0;
      flush = 1'b1;
      #1;
      check_eq("mrst.ready_low", in_ready, 1'b1);
      step();
      check_eq("mrst.out_valid", out_valid, 1'b0);
      check_eq("mrst.dec_count", dec_count, 16'd0);
      check_eq("mrst.bundle", {cond, op_class, funct, rd, rs, rm, use_imm}, 23'd0);
      check_eq("mrst.inm", inm, 32'd0);
      flush = 1'b0;
      step();
      check_eq("mrst.ignored", out_valid, 1'b0);
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      check_eq("mrst.still_empty", out_valid, 1'b0);
      check_eq("mrst.ready_after", in_ready, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_decode_pipe.md
Name: instr_decode_pipe

Overview:
- Next-generation instruction decoder stage, between fetch and register-read/execute.
- Decodes 32-bit ARM-style instructions into a structured control bundle:
  - data-processing (register and rotated immediate),
  - load/store (immediate and register offset),
  - branch/branch-with-link.
- Adds over the previous decoder: valid/ready handshake on both sides, optional skid slot, pipeline flush, illegal-instruction flag, decoded-instruction counter, and a parametrised immediate width with sign/rotate expansion.

Parameters:
- DATA_W, 32, width of expanded immediate output; legal range 32..64.
- SKID_EN, 1, 1 = two-entry output buffer (full throughput under backpressure); 0 = single register.
- CNT_W, 16, width of decoded-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all buffered and same-cycle-accepted instructions.
- in_valid  in  1  instruction word valid.
- in_ready  out  1  decoder can accept this cycle.
- instruction  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts bundle.
- cond  out  4  condition field [31:28].
- op_class  out  2  0=DP, 1=MEM, 2=BR, 3=ILLEGAL.
- funct  out  4  DP opcode [24:21]; 0 otherwise.
- set_flags  out  1  DP S bit [20].
- use_imm  out  1  operand2/offset is imm (not rm).
- rd, rs, rm  out  4 each  [15:12], [19:16], [3:0]; unused fields are 0.
- inm  out  DATA_W  expanded immediate.
- useMemory  out  1  MEM class.
- wMemory  out  1  store (L bit [20]==0) for MEM class.
- up, byte_acc, pre_idx, wback  out  1 each  MEM U[23], B[22], P[24], W[21].
- link  out  1  BR with L bit [24].
- illegal  out  1  op_class==3.
- dec_count  out  CNT_W  completed output handshakes.

Behaviour:
- Decode rules by instruction[27:26]:
  - 00 DP:
    - I=[25]=1: use_imm=1, inm = zero-ext(imm8 ror (2*rot[11:8])) computed at 32 bits, then zero-extended to DATA_W; rm=0.
    - I=0: use_imm=0, rm=[3:0], inm=0.
  - 01 MEM:
    - I=[25]=0: use_imm=1, inm=zero-ext imm12 [11:0], rm=0.
    - I=1: use_imm=0, rm=[3:0], inm=0.
    - funct=0.
  - 10 BR: inm = sign-ext(imm24) << 2 to DATA_W; link=[24]; rd=rs=rm=0.
  - 11: op_class=ILLEGAL, illegal=1, all other fields 0 except cond.
- Latency: 1 cycle from accept (in_valid && in_ready) to out_valid.
- Output bundle is stable while out_valid && !out_ready.
- SKID_EN=1:
  - Slots main/skid.
  - in_ready = !skid_valid.
  - Accept with main empty or draining: goes to main.
  - Accept while main stalled: goes to skid.
  - On main drain with skid full: skid moves to main the same edge.
  - Order is always preserved.
  - Simultaneous accept + drain with skid full cannot occur (in_ready=0).
- SKID_EN=0: in_ready = !out_valid || out_ready.
- flush, synchronous:
  - Next cycle: out_valid=0 and skid empty.
  - Any instruction accepted in the flush cycle is dropped.
  - in_ready=1 in the cycle after flush.
  - dec_count does not count dropped instructions.
- dec_count increments on each out_valid && out_ready edge and wraps at 2^CNT_W.
- Reset (reset==0 at an edge):
  - All outputs 0, including out_valid, dec_count and both slots.
  - in_ready reads 1 but in_valid is ignored while reset is low.
  - Reset mid-stream discards everything.
  - Reset dominates flush.

Decomposition:
- Package decode_pkg: op_class_t enum (OP_DP, OP_MEM, OP_BR, OP_ILL), decoded_t packed struct (all bundle fields, inm parametrised via DATA_W localparam defaults), field-position constants.
- Sub-module decode_fields: purely combinational instruction → decoded_t, including rotator and sign extension.
- Top module holds the slots, handshake, flush and counter.

Test Plan:
- Immediate DP:
  - 0xE2821004 (ADD r1,r2,#4) → DP, funct=4, rd=1, rs=2, use_imm=1, inm=4.
  - 0xE3A004FF → inm=0xFF000000, funct=0xD.
- Memory:
  - 0xE5843008 (STR r3,[r4,#8]) → useMemory=1, wMemory=1, up=1, pre_idx=1, inm=8.
  - 0xE5143008 (LDR r3,[r4,#-8]) → wMemory=0, up=0.
- Branch:
  - 0xEAFFFFFE → BR, link=0, inm=0xFFFFFFF8 (DATA_W=64: 0xFFFFFFFFFFFFFFF8).
  - 0xEB000010 → link=1, inm=0x40.
- Illegal: 0xEC000000 → illegal=1, op_class=3, rd=rs=rm=0, inm=0, cond=0xE.
- Backpressure (SKID_EN=1): out_ready=0, drive 3 instructions back-to-back.
  - First two accepted; in_ready=0 after the second.
  - Raise out_ready: outputs emerge in order, dec_count=3.
- Flush/reset:
  - Flush with both slots full plus a same-cycle accept → out_valid=0 next cycle, dec_count unchanged.
  - reset=0 for one cycle mid-stream → all outputs 0.
